// File: rtl/csr_wport_arbiter_pkg.sv
// Shared types for the CSR write-port arbiter: FSM states, grant selector, counter width.
package csr_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EXU  = 2'd1,
    GNT_INT  = 2'd2
  } gnt_t;

endpackage

// File: rtl/csr_wport_arbiter_if.sv
// Bundle of the EXU request, trap-controller beat and CSR write-port signals.
interface csr_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              exu_valid_i;
  logic              exu_ready_o;
  logic [ADDR_W-1:0] exu_waddr_i;
  logic [DATA_W-1:0] exu_wdata_i;
  logic              int_valid_i;
  logic              int_ready_o;
  logic [ADDR_W-1:0] int_waddr_i;
  logic [DATA_W-1:0] int_wdata_i;
  logic              int_last_i;
  logic              csr_we_o;
  logic [ADDR_W-1:0] csr_waddr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic              busy_o;

  modport master (
    output exu_valid_i, exu_waddr_i, exu_wdata_i,
    output int_valid_i, int_waddr_i, int_wdata_i, int_last_i,
    input  exu_ready_o, int_ready_o,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, busy_o
  );

  modport slave (
    input  exu_valid_i, exu_waddr_i, exu_wdata_i,
    input  int_valid_i, int_waddr_i, int_wdata_i, int_last_i,
    output exu_ready_o, int_ready_o,
    output csr_we_o, csr_waddr_o, csr_wdata_o, busy_o
  );

endinterface

// File: rtl/csr_wport_arbiter_wbuf.sv
// One-entry holding buffer for EXU CSR writes; a pop and a push may happen in the same cycle.
module csr_arb_wbuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  assign ready = ~valid_reg | pop;
  assign valid = valid_reg;
  assign addr  = addr_reg;
  assign data  = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
    end else if (push && ready) begin
      valid_reg <= 1'b1;
    end else if (pop) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      data_reg <= '0;
    end else if (push && ready) begin
      addr_reg <= push_addr;
      data_reg <= push_data;
    end
  end

endmodule

// File: rtl/csr_wport_arbiter.sv
// Shares the CSR-file write port between buffered EXU writes and unbuffered trap bursts.
// Optional stall counter output is enabled with `define CSR_ARB_PERF_EN.
module csr_wport_arbiter
  import csr_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  csr_arb_if.slave    bus
`ifdef CSR_ARB_PERF_EN
  ,
  output logic [31:0] exu_stall_cnt_o
`endif
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  state_t                  state_reg, state_next;
  logic [STARVE_CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  gnt_t                    gnt_sel;

  logic              buf_valid, buf_ready, buf_grant, int_grant;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  logic              csr_we_reg;
  logic [ADDR_W-1:0] csr_waddr_reg;
  logic [DATA_W-1:0] csr_wdata_reg;

  csr_arb_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.exu_valid_i),
    .push_addr (bus.exu_waddr_i),
    .push_data (bus.exu_wdata_i),
    .pop       (buf_grant),
    .ready     (buf_ready),
    .valid     (buf_valid),
    .addr      (buf_addr),
    .data      (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Grant selection; nothing is granted while reset is held so no write escapes the reset cycle.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (!rst) begin
      if (state_reg == S_BURST) begin
        if (bus.int_valid_i) gnt_sel = GNT_INT;
      end else if (bus.int_valid_i && buf_valid && (starve_cnt_reg == STARVE_MAX)) begin
        gnt_sel = GNT_EXU;
      end else if (bus.int_valid_i) begin
        gnt_sel = GNT_INT;
      end else if (buf_valid) begin
        gnt_sel = GNT_EXU;
      end
    end
  end

  assign buf_grant = (gnt_sel == GNT_EXU);
  assign int_grant = (gnt_sel == GNT_INT);

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    if (state_reg == S_IDLE) begin
      if (int_grant && !bus.int_last_i) state_next = S_BURST;
      if (buf_grant) begin
        starve_cnt_next = '0;
      end else if (int_grant && buf_valid && (starve_cnt_reg != '1)) begin
        starve_cnt_next = starve_cnt_reg + 1'b1;
      end
    end else if (int_grant && bus.int_last_i) begin
      state_next = S_IDLE;
    end
    if (!buf_valid) starve_cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_we_reg    <= 1'b0;
      csr_waddr_reg <= '0;
      csr_wdata_reg <= '0;
    end else begin
      csr_we_reg <= int_grant | buf_grant;
      if (int_grant) begin
        csr_waddr_reg <= bus.int_waddr_i;
        csr_wdata_reg <= bus.int_wdata_i;
      end else if (buf_grant) begin
        csr_waddr_reg <= buf_addr;
        csr_wdata_reg <= buf_data;
      end
    end
  end

  assign bus.exu_ready_o = buf_ready;
  assign bus.int_ready_o = int_grant;
  assign bus.csr_we_o    = csr_we_reg;
  assign bus.csr_waddr_o = csr_waddr_reg;
  assign bus.csr_wdata_o = csr_wdata_reg;
  assign bus.busy_o      = buf_valid | (state_reg == S_BURST);

`ifdef CSR_ARB_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (buf_valid && !buf_grant && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign exu_stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_csr_wport_arbiter.sv
// Directed bench for csr_wport_arbiter: single EXU write, trap burst, starvation, reset mid-burst.
module tb_csr_wport_arbiter;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  csr_arb_if #(.ADDR_W(32), .DATA_W(32)) b ();

`ifdef CSR_ARB_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_base;
`endif

  csr_wport_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
`ifdef CSR_ARB_PERF_EN
    ,
    .exu_stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_we"}, 64'(b.csr_we_o), 64'(we));
    if (we) begin
      chk({tag, "_addr"}, 64'(b.csr_waddr_o), 64'(addr));
      chk({tag, "_data"}, 64'(b.csr_wdata_o), 64'(data));
    end
  endtask

  task automatic idle_inputs();
    b.exu_valid_i = 1'b0;
    b.exu_waddr_i = '0;
    b.exu_wdata_i = '0;
    b.int_valid_i = 1'b0;
    b.int_waddr_i = '0;
    b.int_wdata_i = '0;
    b.int_last_i  = 1'b0;
  endtask

  task automatic exu_req(input logic [31:0] addr, input logic [31:0] data);
    b.exu_valid_i = 1'b1;
    b.exu_waddr_i = addr;
    b.exu_wdata_i = data;
  endtask

  task automatic int_req(input logic [31:0] addr, input logic [31:0] data, input logic last);
    b.int_valid_i = 1'b1;
    b.int_waddr_i = addr;
    b.int_wdata_i = data;
    b.int_last_i  = last;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_we",        64'(b.csr_we_o),    64'h0);
    chk("rst_waddr",     64'(b.csr_waddr_o), 64'h0);
    chk("rst_wdata",     64'(b.csr_wdata_o), 64'h0);
    chk("rst_exu_ready", 64'(b.exu_ready_o), 64'h1);
    chk("rst_int_ready", 64'(b.int_ready_o), 64'h0);
    chk("rst_busy",      64'(b.busy_o),      64'h0);
    $display("txn reset done");

    // Single EXU write: visible two cycles after accept.
    exu_req(32'h300, 32'h8);
    #1 chk("single_exu_ready", 64'(b.exu_ready_o), 64'h1);
    tick();
    b.exu_valid_i = 1'b0;
    chk("single_busy1", 64'(b.busy_o), 64'h1);
    wr("single_c1", 1'b0, 32'h0, 32'h0);
    tick();
    wr("single_c2", 1'b1, 32'h300, 32'h8);
    chk("single_busy2", 64'(b.busy_o), 64'h0);
    tick();
    wr("single_c3", 1'b0, 32'h0, 32'h0);
    $display("txn single exu write 0x300 <= 0x8");

    // Three-beat trap burst with an EXU write arriving on beat 1.
    int_req(32'h341, 32'h8000_0010, 1'b0);
    exu_req(32'h305, 32'h55);
    #1;
    chk("burst_b1_int_ready", 64'(b.int_ready_o), 64'h1);
    chk("burst_b1_exu_ready", 64'(b.exu_ready_o), 64'h1);
    tick();
    b.exu_valid_i = 1'b0;
    wr("burst_w1", 1'b1, 32'h341, 32'h8000_0010);
    int_req(32'h342, 32'h8000_000B, 1'b0);
    #1;
    chk("burst_b2_exu_ready", 64'(b.exu_ready_o), 64'h0);
    chk("burst_b2_int_ready", 64'(b.int_ready_o), 64'h1);
    chk("burst_b2_busy",      64'(b.busy_o),      64'h1);
    tick();
    wr("burst_w2", 1'b1, 32'h342, 32'h8000_000B);
    int_req(32'h300, 32'h1880, 1'b1);
    #1 chk("burst_b3_exu_ready", 64'(b.exu_ready_o), 64'h0);
    tick();
    wr("burst_w3", 1'b1, 32'h300, 32'h1880);
    b.int_valid_i = 1'b0;
    b.int_last_i  = 1'b0;
    #1 chk("burst_pop_exu_ready", 64'(b.exu_ready_o), 64'h1);
    tick();
    wr("burst_w4", 1'b1, 32'h305, 32'h55);
    tick();
    wr("burst_end", 1'b0, 32'h0, 32'h0);
    chk("burst_end_busy", 64'(b.busy_o), 64'h0);
    $display("txn trap burst mepc/mcause/mstatus then exu 0x305");

    // Starvation: EXU pending behind back-to-back single-beat trap writes.
    exu_req(32'h340, 32'hAA);
    int_req(32'h344, 32'h101, 1'b1);
    tick();
    b.exu_valid_i = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      wr("starve_int", 1'b1, 32'h344, 32'(32'h100 + k - 1));
      b.int_wdata_i = 32'(32'h100 + k);
      #1 chk("starve_int_ready", 64'(b.int_ready_o), 64'h1);
      tick();
    end
    wr("starve_int5", 1'b1, 32'h344, 32'h105);
    b.int_wdata_i = 32'h106;
    #1;
    chk("starve_limit_int_ready", 64'(b.int_ready_o), 64'h0);
    chk("starve_limit_exu_ready", 64'(b.exu_ready_o), 64'h1);
    tick();
    wr("starve_exu", 1'b1, 32'h340, 32'hAA);
    #1 chk("starve_resume_int_ready", 64'(b.int_ready_o), 64'h1);
    tick();
    wr("starve_resume", 1'b1, 32'h344, 32'h106);
    idle_inputs();
    tick();
    wr("starve_end", 1'b0, 32'h0, 32'h0);
    $display("txn starvation: 4 int writes then exu then int");

    // Buffer and trap both pending with counter 0: trap first, then EXU.
    exu_req(32'h304, 32'h1234);
    tick();
    b.exu_valid_i = 1'b0;
    int_req(32'h343, 32'h77, 1'b1);
    #1;
    chk("simul_int_ready", 64'(b.int_ready_o), 64'h1);
    chk("simul_exu_ready", 64'(b.exu_ready_o), 64'h0);
    tick();
    idle_inputs();
    wr("simul_int", 1'b1, 32'h343, 32'h77);
    #1 chk("simul_pop_exu_ready", 64'(b.exu_ready_o), 64'h1);
    tick();
    wr("simul_exu", 1'b1, 32'h304, 32'h1234);
    tick();
    wr("simul_end", 1'b0, 32'h0, 32'h0);
    $display("txn simultaneous request: int 0x343 then exu 0x304");

    // Reset after beat 1 of a burst with the buffer loaded.
    int_req(32'h341, 32'hDEAD, 1'b0);
    exu_req(32'h301, 32'h99);
    tick();
    b.exu_valid_i = 1'b0;
    wr("rstmid_w1", 1'b1, 32'h341, 32'hDEAD);
    int_req(32'h342, 32'hBEEF, 1'b0);
    rst = 1'b1;
    #1 chk("rstmid_int_ready", 64'(b.int_ready_o), 64'h0);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    wr("rstmid_c1", 1'b0, 32'h0, 32'h0);
    chk("rstmid_exu_ready", 64'(b.exu_ready_o), 64'h1);
    chk("rstmid_busy",      64'(b.busy_o),      64'h0);
    tick();
    wr("rstmid_c2", 1'b0, 32'h0, 32'h0);
    $display("txn reset mid-burst discards buffered write");

`ifdef CSR_ARB_PERF_EN
    // Stall counter over a three-beat burst with the EXU buffer held.
    exu_req(32'h302, 32'h5);
    tick();
    b.exu_valid_i = 1'b0;
    stall_base = stall_cnt;
    int_req(32'h341, 32'h1, 1'b0);
    tick();
    int_req(32'h342, 32'h2, 1'b0);
    tick();
    int_req(32'h300, 32'h3, 1'b1);
    tick();
    idle_inputs();
    chk("perf_stall_cnt", 64'(stall_cnt), 64'(stall_base + 32'd3));
    tick();
    tick();
    $display("txn perf counter over 3-beat burst");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
